pr_dma_master: RTL and testbench
================================

# pr_dma_master

Bus initiator for the processor-side peripheral bus (PrAddr/PrWe/PrWD/PrRD). It sits in parallel with the CPU in front of the device bridge: a two-input bus multiplexer selects which master drives the bus, and that mux is outside this block. It copies a programmable number of 32-bit words from a source device address to a destination device address, for example DIP-switch words to the LED or digital-tube registers, without CPU load/store traffic. On completion it raises an interrupt line that feeds a spare HWInt bit.

## Interface
Parameters:
- CNT_W, 16, width of the word-count register; maximum transfer is 2^CNT_W-1 words.
- STRIDE, 4, byte increment applied to an address after each word.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- cfg_we  in  1  configuration write strobe (CPU side).
- cfg_addr  in  2  register select: 0 SRC, 1 DST, 2 CNT, 3 CTRL.
- cfg_wd  in  32  configuration write data.
- cfg_rd  out  32  combinational readback of the selected register.
- PrWe  out  1  bus write enable.
- PrAddr  out  32  bus address.
- PrWD  out  32  bus write data.
- PrRD  in  32  bus read data, valid combinationally in the same cycle as PrAddr.
- busy  out  1  high in the RD and WR states; the external mux grants this block the bus while busy=1.
- irq  out  1  level interrupt, equal to done & ie.

## Operation
Registers:
- SRC and DST store bits [31:2]; bits [1:0] always read 0.
- CNT reads back the live count of remaining words.
- CTRL bits: bit0 start (write-1 pulse, reads 0), bit1 ie, bit2 done (sticky; write 1 to clear), bit3 fixsrc, bit4 abort (write-1 pulse, reads 0).

Configuration write rules:
- Writes to SRC, DST and CNT while busy=1 are ignored.
- Writes to CTRL are always accepted.
- A start written while busy=1 is ignored.

States:
- IDLE: start=1 → RD if CNT≠0, else DONE.
- RD: drive PrAddr=SRC, PrWe=0, PrWD=0; capture PrRD into the data register at the clock edge → WR.
- WR: drive PrAddr=DST, PrWe=1, PrWD=data. At the edge:
  - CNT←CNT-1 and DST←DST+STRIDE.
  - SRC←SRC+STRIDE unless fixsrc=1.
  - Next state is DONE if the old CNT was 1, else RD.
- DONE: set done=1 → IDLE. DONE lasts one cycle; busy=0.

Boundary rules:
- abort in RD or WR → IDLE at the next edge. done is not set, and CNT, SRC and DST keep their partially advanced values. If abort is written in WR, that cycle's bus write still occurs. abort in IDLE or DONE has no effect.
- Address increment wraps modulo 2^32.
- A done-clear in the same cycle as the DONE state: the set wins and done=1.
- Assert reset mid-transfer → IDLE, bus outputs 0, no further bus cycles.

## Timing
- Reset values: PrWe=0, PrAddr=0, PrWD=0, busy=0, irq=0, cfg_rd=0 (for every cfg_addr). SRC, DST, CNT, CTRL and the data register are all 0.
- Bus outputs are registered-state decodes. In IDLE and DONE they are 0.
- Start written at edge E:
  - First RD occupies cycle E+1.
  - Word k (from 0) reads in cycle E+1+2k and writes in cycle E+2+2k.
- For an N-word transfer:
  - DONE occupies cycle E+1+2N.
  - done and irq rise at edge E+2+2N.
  - busy=1 for exactly 2N cycles.
- CNT=0 start: DONE in cycle E+1, irq at edge E+2, no bus activity.
- irq stays high until done is cleared or ie is cleared; it drops the cycle after the clearing write.

## Configuration
- PR_DMA_FIXED_SRC_EN defined: CTRL bit3 (fixsrc) is implemented, holding SRC constant for every word so a single device register can be polled repeatedly.
- Undefined: bit3 is not stored, always reads 0 and SRC always increments. No other behaviour changes.

## Test plan
- Copy 2 words: SRC=0x7F2C, DST=0x7F38, CNT=2, start. PrRD returns 0x11223344, then 0x55667788. Required bus sequence, one entry per cycle: RD 0x7F2C; WR 0x7F38 with 0x11223344; RD 0x7F30; WR 0x7F3C with 0x55667788. Then done=1 and CNT=0.
- ie=1, CNT=1: irq rises exactly 4 cycles after the start edge. Writing CTRL=0x6 (keep ie, clear done) drops irq the following cycle.
- CNT=0, start: no cycle with busy=1 or PrWe=1, and done=1 two edges after start.
- CNT=5, abort written during the second WR: that write completes and the block then returns to IDLE. Required state afterwards: CNT=3, done=0, irq=0, DST advanced by 8.
- Reset pulled low during RD of a 4-word copy: PrWe, PrAddr, busy and CNT are 0 immediately, and the bus stays quiet after release.
- Build with PR_DMA_FIXED_SRC_EN, fixsrc=1, CNT=3, SRC=0x7F40: all three reads use 0x7F40, DST increments by 4 per word. Build without the macro: CTRL readback bit3 is 0 and SRC increments.

Source files
------------

// File: rtl/pr_dma_master_if.sv
// rtl/pr_dma_master_if.sv - processor-side peripheral bus (PrAddr/PrWe/PrWD/PrRD) between initiator and bridge mux
interface pr_dma_master_if;
    logic        PrWe;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic [31:0] PrRD;

    modport master (output PrWe, output PrAddr, output PrWD, input PrRD);
    modport slave  (input PrWe, input PrAddr, input PrWD, output PrRD);
endinterface

// File: rtl/pr_dma_master.sv
// rtl/pr_dma_master.sv - word-copy bus initiator with done interrupt; PR_DMA_FIXED_SRC_EN enables CTRL.fixsrc
module pr_dma_master #(
    parameter int CNT_W  = 16,
    parameter int STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [31:0]           cfg_wd,
    output logic [31:0]           cfg_rd,
    pr_dma_master_if.master       bus,
    output logic                  busy,
    output logic                  irq
);
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t             r_state;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_data;
    logic               r_ie;
    logic               r_done;
    logic               w_fixsrc;
    logic               w_busy;
    logic               w_ctrl_we;
    logic               w_start;
    logic               w_abort;

    assign w_busy    = (r_state == S_RD) || (r_state == S_WR);
    assign w_ctrl_we = cfg_we && (cfg_addr == 2'd3);
    assign w_start   = w_ctrl_we && cfg_wd[0];
    assign w_abort   = w_ctrl_we && cfg_wd[4];

`ifdef PR_DMA_FIXED_SRC_EN
    logic r_fixsrc;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_fixsrc <= 1'b0;
        else if (w_ctrl_we)
            r_fixsrc <= cfg_wd[3];
    end
    assign w_fixsrc = r_fixsrc;
`else
    assign w_fixsrc = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ie    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Address/count registers belong to the FSM while a copy is in flight.
            if (cfg_we && !w_busy) begin
                case (cfg_addr)
                    2'd0:    r_src <= cfg_wd & ADDR_MASK;
                    2'd1:    r_dst <= cfg_wd & ADDR_MASK;
                    2'd2:    r_cnt <= cfg_wd[CNT_W-1:0];
                    default: ;
                endcase
            end
            if (w_ctrl_we) begin
                r_ie <= cfg_wd[1];
                if (cfg_wd[2])
                    r_done <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start)
                        r_state <= (r_cnt != '0) ? S_RD : S_DONE;
                end
                S_RD: begin
                    r_data  <= bus.PrRD;
                    r_state <= w_abort ? S_IDLE : S_WR;
                end
                S_WR: begin
                    // The write in flight completes even when aborted, so pointers still advance.
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_dst <= (r_dst + 32'(STRIDE)) & ADDR_MASK;
                    if (!w_fixsrc)
                        r_src <= (r_src + 32'(STRIDE)) & ADDR_MASK;
                    if (w_abort)
                        r_state <= S_IDLE;
                    else if (r_cnt == CNT_W'(1))
                        r_state <= S_DONE;
                    else
                        r_state <= S_RD;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.PrWe   = 1'b0;
        bus.PrAddr = '0;
        bus.PrWD   = '0;
        case (r_state)
            S_RD: bus.PrAddr = r_src;
            S_WR: begin
                bus.PrWe   = 1'b1;
                bus.PrAddr = r_dst;
                bus.PrWD   = r_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        cfg_rd = '0;
        case (cfg_addr)
            2'd0:    cfg_rd = r_src;
            2'd1:    cfg_rd = r_dst;
            2'd2:    cfg_rd = 32'(r_cnt);
            default: cfg_rd = {27'd0, 1'b0, w_fixsrc, r_done, r_ie, 1'b0};
        endcase
    end

    assign busy = w_busy;
    assign irq  = r_done & r_ie;

endmodule

// File: tb/tb_pr_dma_master.sv
// tb/tb_pr_dma_master.sv - randomized self-checking bench for pr_dma_master against a word-copy reference model
module tb_pr_dma_master;
`ifdef PR_DMA_FIXED_SRC_EN
    localparam bit FIX_EN = 1'b1;
`else
    localparam bit FIX_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wd;
    logic [31:0] cfg_rd;
    logic        busy;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] words [0:15];

    pr_dma_master_if bus_if ();

    pr_dma_master #(.CNT_W(16), .STRIDE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wd   (cfg_wd),
        .cfg_rd   (cfg_rd),
        .bus      (bus_if.master),
        .busy     (busy),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_wd   = d;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rd;
    endtask

    // Reference: word k reads src+4k (or src when fixed) and writes words[k] to dst+4k.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int n,
                            input bit ie, input bit fix);
        logic [31:0] v;
        logic [31:0] s_exp;
        bit          eff_fix;
        eff_fix = FIX_EN & fix;
        cfg_write(2'd0, src);
        cfg_write(2'd1, dst);
        cfg_write(2'd2, 32'(n));
        cfg_write(2'd3, (32'(fix) << 3) | 32'h4 | (32'(ie) << 1) | 32'h1);
        for (int k = 0; k < n; k++) begin
            s_exp = eff_fix ? src : src + 32'(4 * k);
            @(negedge clk);
            check("rd_busy", 32'(busy), 32'd1);
            check("rd_we", 32'(bus_if.PrWe), 32'd0);
            check("rd_addr", bus_if.PrAddr, s_exp);
            check("rd_wd", bus_if.PrWD, 32'd0);
            check("rd_irq", 32'(irq), 32'd0);
            bus_if.PrRD = words[k];
            @(negedge clk);
            bus_if.PrRD = $urandom;
            check("wr_busy", 32'(busy), 32'd1);
            check("wr_we", 32'(bus_if.PrWe), 32'd1);
            check("wr_addr", bus_if.PrAddr, dst + 32'(4 * k));
            check("wr_wd", bus_if.PrWD, words[k]);
        end
        @(negedge clk);
        check("done_busy", 32'(busy), 32'd0);
        check("done_we", 32'(bus_if.PrWe), 32'd0);
        check("done_addr", bus_if.PrAddr, 32'd0);
        check("done_irq", 32'(irq), 32'd0);
        @(negedge clk);
        check("end_irq", 32'(irq), 32'(ie));
        rd_reg(2'd2, v); check("end_cnt", v, 32'd0);
        rd_reg(2'd0, v); check("end_src", v, eff_fix ? src : src + 32'(4 * n));
        rd_reg(2'd1, v); check("end_dst", v, dst + 32'(4 * n));
        rd_reg(2'd3, v); check("end_ctrl", v, (32'(eff_fix) << 3) | 32'h4 | (32'(ie) << 1));
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] s0;
        logic [31:0] d0;
        reset       = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = 2'd0;
        cfg_wd      = '0;
        bus_if.PrRD = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we", 32'(bus_if.PrWe), 32'd0);
        check("rst_addr", bus_if.PrAddr, 32'd0);
        check("rst_wd", bus_if.PrWD, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), v);
            check("rst_cfg_rd", v, 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed 2-word copy
        words[0] = 32'h1122_3344;
        words[1] = 32'h5566_7788;
        run_xfer(32'h7F2C, 32'h7F38, 2, 1'b0, 1'b0);

        // Single word with interrupt, then clear done keeping ie
        words[0] = $urandom;
        run_xfer(32'h7F00, 32'h7F10, 1, 1'b1, 1'b0);
        cfg_write(2'd3, 32'h6);
        @(negedge clk);
        check("irq_clear", 32'(irq), 32'd0);
        rd_reg(2'd3, v); check("ctrl_after_clear", v, 32'h2);

        // Zero-length start
        run_xfer(32'h100, 32'h200, 0, 1'b1, 1'b0);

        // Abort during second write
        s0 = 32'h0000_7F00;
        d0 = 32'h0000_7F80;
        cfg_write(2'd0, s0);
        cfg_write(2'd1, d0);
        cfg_write(2'd2, 32'd5);
        cfg_write(2'd3, 32'h7);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_we", 32'(bus_if.PrWe), 32'(c % 2));
            bus_if.PrRD = $urandom;
        end
        check("abort_wr_addr", bus_if.PrAddr, d0 + 32'd4);
        cfg_we   = 1'b1;
        cfg_addr = 2'd3;
        cfg_wd   = 32'h12;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_idle_busy", 32'(busy), 32'd0);
            check("abort_idle_we", 32'(bus_if.PrWe), 32'd0);
        end
        check("abort_irq", 32'(irq), 32'd0);
        rd_reg(2'd2, v); check("abort_cnt", v, 32'd3);
        rd_reg(2'd1, v); check("abort_dst", v, d0 + 32'd8);
        rd_reg(2'd0, v); check("abort_src", v, s0 + 32'd8);
        rd_reg(2'd3, v); check("abort_ctrl", v, 32'h2);

        // Reset during the first read of a 4-word copy
        cfg_write(2'd2, 32'd4);
        cfg_write(2'd3, 32'h5);
        @(negedge clk);
        check("prerst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_we", 32'(bus_if.PrWe), 32'd0);
        check("midrst_addr", bus_if.PrAddr, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rd_reg(2'd2, v); check("midrst_cnt", v, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("postrst_busy", 32'(busy), 32'd0);
            check("postrst_we", 32'(bus_if.PrWe), 32'd0);
        end

        // Fixed-source polling (SRC increments when the feature is not built)
        for (int k = 0; k < 3; k++) words[k] = $urandom;
        run_xfer(32'h7F40, 32'h7F50, 3, 1'b0, 1'b1);
        cfg_write(2'd3, 32'h8);
        rd_reg(2'd3, v); check("fixsrc_rb", v & 32'h8, 32'(FIX_EN) << 3);

        // Randomized transfers, some straddling the 2^32 wrap
        for (int t = 0; t < 16; t++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) words[k] = $urandom;
            s0 = (t % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            d0 = (t % 5 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            run_xfer(s0, d0, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
